// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: a small circular FIFO with valid/ready handshake,
// a stall input that freezes the head, a flush input, and a bubble value shown when empty.
module pipe_stage_buf #(
  parameter int                       PAYLOAD_WIDTH = 96,
  parameter int                       DEPTH         = 2,
  parameter logic [PAYLOAD_WIDTH-1:0] BUBBLE        = '0,
  parameter int                       CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_data,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic [CNT_WIDTH-1:0]     count_o,
  output logic                     overflow_o
);

  localparam int                     PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0]   DEPTH_C   = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST  = PTR_WIDTH'(DEPTH - 1);

  logic [PAYLOAD_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]     rd_ptr_r;
  logic [PTR_WIDTH-1:0]     wr_ptr_r;
  logic [CNT_WIDTH-1:0]     count_r;
  logic                     overflow_r;
  logic                     not_empty_s;
  logic                     push_s;
  logic                     pop_s;

  // DEPTH need not be a power of two, so wrap by compare rather than by masking.
  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // in_ready depends on registered occupancy only, so a full buffer refuses a push even while popping.
  assign in_ready    = (count_r < DEPTH_C);
  assign not_empty_s = (count_r != '0);
  assign out_valid   = not_empty_s & ~hold_i;
  assign out_data    = not_empty_s ? mem_r[rd_ptr_r] : BUBBLE;
  assign push_s      = in_valid & in_ready & ~flush_i;
  assign pop_s       = out_valid & out_ready & ~flush_i;
  assign count_o     = count_r;
  assign overflow_o  = overflow_r;

  // Payload storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Occupancy, pointers and sticky overflow flag; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
      if (in_valid && !in_ready) begin
        overflow_r <= 1'b1;
      end
    end
  end

  pipe_stage_buf_chk #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count_r),
    .push     (push_s),
    .pop      (pop_s),
    .in_ready (in_ready)
  );

endmodule

// Occupancy invariants: bounded by DEPTH, no pop when empty, no push when full.
module pipe_stage_buf_chk #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic [CNT_WIDTH-1:0] count,
  input logic                 push,
  input logic                 pop,
  input logic                 in_ready
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  count_le_depth: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
  no_pop_empty:   assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count != '0));
  no_push_full:   assert property (@(posedge clk) disable iff (!rst_n) push |-> in_ready);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance, each checked every
// cycle against a queue scoreboard of accepted payloads.
module tb_pipe_stage_buf;

  localparam logic [7:0] A_BUB = 8'hE5;
  localparam logic [7:0] B_BUB = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_iv, a_ir, a_ov, a_or, a_hold, a_flush, a_ofl;
  logic [7:0] a_id, a_od;
  logic [1:0] a_cnt;
  logic       b_iv, b_ir, b_ov, b_or, b_hold, b_flush, b_ofl;
  logic [7:0] b_id, b_od;
  logic [1:0] b_cnt;

  pipe_stage_buf #(.PAYLOAD_WIDTH(8), .DEPTH(2), .BUBBLE(A_BUB)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .hold_i(a_hold),
    .flush_i(a_flush), .count_o(a_cnt), .overflow_o(a_ofl)
  );

  pipe_stage_buf #(.PAYLOAD_WIDTH(8), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .hold_i(b_hold),
    .flush_i(b_flush), .count_o(b_cnt), .overflow_o(b_ofl)
  );

  int         checks = 0;
  int         passes = 0;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic       a_ofm = 1'b0;
  logic       b_ofm = 1'b0;
  logic       b_acc;
  int         k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_dut(input string n, input logic [1:0] cnt, input logic ir,
                           input logic ov, input logic [7:0] od, input logic ofl,
                           input int qsize, input logic [7:0] head, input logic hold,
                           input logic ofm, input int depth, input logic [7:0] bub);
    check({n, "_count"}, 32'(cnt), qsize);
    check({n, "_in_ready"}, 32'(ir), 32'(qsize < depth));
    check({n, "_out_valid"}, 32'(ov), 32'((qsize != 0) && !hold));
    check({n, "_out_data"}, 32'(od), 32'((qsize != 0) ? head : bub));
    check({n, "_overflow"}, 32'(ofl), 32'(ofm));
  endtask

  // One clock: predict handshakes from the model, advance the model, then compare.
  task automatic tick();
    bit a_irm, a_push, a_pop, b_irm, b_push, b_pop;
    a_irm  = a_q.size() < 2;
    a_push = a_iv && a_irm && !a_flush;
    a_pop  = (a_q.size() != 0) && !a_hold && a_or && !a_flush;
    b_irm  = b_q.size() < 3;
    b_push = b_iv && b_irm && !b_flush;
    b_pop  = (b_q.size() != 0) && !b_hold && b_or && !b_flush;
    @(posedge clk);
    if (!rst_n) begin
      a_q.delete(); b_q.delete();
      a_ofm = 1'b0; b_ofm = 1'b0;
      b_acc = 1'b0;
    end else begin
      if (a_flush) a_q.delete();
      else begin
        if (a_pop) a_q.delete(0);
        if (a_push) a_q.push_back(a_id);
      end
      if (a_iv && !a_irm && !a_flush) a_ofm = 1'b1;
      if (b_flush) b_q.delete();
      else begin
        if (b_pop) b_q.delete(0);
        if (b_push) b_q.push_back(b_id);
      end
      if (b_iv && !b_irm && !b_flush) b_ofm = 1'b1;
      b_acc = b_push;
    end
    #1;
    check_dut("a", a_cnt, a_ir, a_ov, a_od, a_ofl, a_q.size(),
              (a_q.size() != 0) ? a_q[0] : 8'h00, a_hold, a_ofm, 2, A_BUB);
    check_dut("b", b_cnt, b_ir, b_ov, b_od, b_ofl, b_q.size(),
              (b_q.size() != 0) ? b_q[0] : 8'h00, b_hold, b_ofm, 3, B_BUB);
  endtask

  initial begin
    // Reset held two cycles with traffic offered
    rst_n = 1'b0;
    a_iv = 1'b1; a_id = 8'h99; a_or = 1'b0; a_hold = 1'b0; a_flush = 1'b0;
    b_iv = 1'b1; b_id = 8'h98; b_or = 1'b0; b_hold = 1'b0; b_flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1; a_iv = 1'b0; b_iv = 1'b0;
    tick();

    // Stream through DEPTH=2
    a_or = 1'b1; a_iv = 1'b1;
    a_id = 8'h11; tick();
    a_id = 8'h22; tick();
    a_id = 8'h33; tick();
    a_iv = 1'b0; tick();

    // Backpressure: third offer refused, then a full pop cycle still refuses a push
    a_or = 1'b0; a_iv = 1'b1;
    a_id = 8'h41; tick();
    a_id = 8'h42; tick();
    a_id = 8'h43; tick();
    a_or = 1'b1; a_id = 8'h44; tick();
    a_iv = 1'b0; tick();
    tick();

    // Flush with a simultaneous push
    a_or = 1'b0; a_iv = 1'b1;
    a_id = 8'h61; tick();
    a_id = 8'h62; tick();
    a_flush = 1'b1; a_id = 8'h55; tick();
    a_flush = 1'b0; a_iv = 1'b0; tick();

    // Hold freezes the head
    a_iv = 1'b1; a_id = 8'hAB; tick();
    a_iv = 1'b0; a_hold = 1'b1; a_or = 1'b1;
    tick(); tick(); tick();
    a_hold = 1'b0;
    #1;
    check("a_release_valid", 32'(a_ov), 32'(1));
    tick();

    // Pointer wrap in DEPTH=3 with varying out_ready
    k = 0;
    for (int i = 0; i < 30; i++) begin
      b_iv = (k < 10);
      b_id = 8'h80 + 8'(k);
      b_or = ((i % 3) != 1);
      tick();
      if (b_acc) k++;
    end
    check("b_pushed_total", 32'(k), 32'(10));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
